fp_addsub_round_pack: RTL
=========================

# fp_addsub_round_pack

Parametrised, pipelined round-and-pack stage for the floating-point add/sub datapath. It takes the normalised sum, with guard/round/sticky bits, operand signs and input-exception codes, and applies one of four IEEE-754 rounding modes. It then packs the result, producing per-result exception flags and a clearable accumulated flag register. The block is the final pipeline stage of the add/sub unit and uses a valid/ready handshake so downstream stalls propagate upstream.

## Interface
- EXP_W, 8, exponent width
- MAN_W, 23, stored mantissa width (result width = 1+EXP_W+MAN_W)
- clk  in  1  clock
- rst_n  in  1  reset (one clock; reset is asynchronous and active-low)
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- zero_sum  in  1  exact sum is zero
- norm_e  in  EXP_W+1  normalised exponent (MSB = overflow bit)
- norm_m  in  MAN_W  normalised mantissa, hidden bit removed
- g, r, s  in  1 each  guard (first dropped bit), round, sticky
- sa, sb, ctrl  in  1 each  A sign, B sign, op (1 = subtract)
- max_ab  in  1  1 = |B| > |A|
- neg_e  in  1  exponent went negative during normalisation
- input_exc  in  5  [4:2] invalid-input cases, [1:0] A/B infinite
- rnd_mode  in  2  0 RNE, 1 RTZ, 2 RUP (+inf), 3 RDN (-inf); sampled with the beat
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- p  out  1+EXP_W+MAN_W  packed result
- flags  out  5  {overflow, underflow, div0, invalid, inexact} for current p
- flags_clr  in  1  clear accumulated flags
- acc_flags  out  5  sticky OR of flags of all delivered results

## Operation
- sb_eff = sb ^ ctrl. Nonzero sign = max_ab ? sb_eff : sa. Zero-sum sign = (sa & sb_eff) for RNE/RTZ/RUP, (sa | sb_eff) for RDN.
- inx = g|r|s. Round-up: RNE g&(r|s|norm_m[0]); RTZ 0; RUP ~sign&inx; RDN sign&inx.
- Rounded mantissa = norm_m + up in MAN_W+1 bits. Carry-out increments the exponent and zeroes the mantissa. zero_sum forces exponent 0 and mantissa 0.
- Exponent overflow: rounded exponent >= 2^EXP_W-1. Result is ±inf when the mode rounds away from zero for that sign (RNE always; RUP if +; RDN if -). Otherwise it is the max finite value: exponent all-ones-minus-one, mantissa all ones.
- Priority, highest first:
  - invalid (|input_exc[4:2]): canonical qNaN with sign 0, exponent all ones, mantissa MSB 1 and the rest 0.
  - infinite input (input_exc[1]|input_exc[0]): ±inf with the computed sign.
  - exponent overflow.
  - normal packing.
- Flags:
  - overflow = exponent overflow & no exception input.
  - underflow = neg_e & inx & no exception input.
  - div0 = 0.
  - invalid = |input_exc[4:2].
  - inexact = (inx|overflow|underflow) & ~invalid.
- acc_flags updates only on an output transfer (out_valid & out_ready): acc_flags <= (flags_clr ? 0 : acc_flags) | flags. When there is no transfer, flags_clr alone clears it. When clear and transfer happen in the same cycle, the new flags survive.

## Timing
- Two register stages:
  - S1 registers the sign, the round decision, the rounded mantissa/exponent and the exception class.
  - S2 registers the overrides, p and flags.
- Latency is 2 cycles from input accept to out_valid when out_ready is held high. Throughput is 1 beat per cycle.
- Handshake:
  - ready2 = ~v2 | out_ready.
  - in_ready = ~v1 | ready2.
  - A stage loads only when its upstream is valid and it is ready.
  - Stalled stages hold their data unchanged.
  - No beat is dropped or duplicated; order is preserved.
  - in_ready depends combinationally on out_ready (no skid buffer).
- Output hold: out_valid, p and flags remain stable while out_valid & ~out_ready.
- Reset (async assert, sync-safe release):
  - v1 = v2 = 0, so out_valid = 0.
  - p = 0, flags = 0, acc_flags = 0.
  - in_ready = 1 after reset.
  - Reset mid-stream discards in-flight beats.
- The rnd_mode change takes effect per beat; there is no global mode state.

## Test plan
- RNE tie-to-even, FP32: norm_e=0x07F, g=1, r=s=0. norm_m=0x000001 -> p=0x3F800002, flags=00001. norm_m=0x000000 -> p=0x3F800000, flags=00001.
- Mantissa carry: norm_e=0x07F, norm_m=0x7FFFFF, g=1, s=1, RNE -> p=0x40000000, flags=00001.
- Overflow by mode: norm_e=0x0FE, norm_m=0x7FFFFF, g=1, sa=0, max_ab=0.
  - RNE -> p=0x7F800000, flags=10001.
  - Same beat with norm_e=0x0FF, RTZ -> p=0x7F7FFFFF, flags=10001.
  - Same beat with sa=1, RUP -> p=0xFF7FFFFF.
- Zero sign: zero_sum=1, sa=0, sb=0, ctrl=1. RNE -> p=0x00000000. RDN -> p=0x80000000. Flags=00000 in both cases.
- Backpressure: drive 6 back-to-back beats, hold out_ready=0 for cycles 3-6 -> in_ready falls once both stages are full. All 6 results are delivered in order, with p stable during the stall.
- Sticky flags: beat with input_exc=5'b00100 -> p=0x7FC00000, flags=00010, acc_flags=00010. Next transfer has flags=00001 with flags_clr=1 in the same cycle -> acc_flags=00001. Assert rst_n low mid-stream -> out_valid=0 and acc_flags=0 immediately.

Source files
------------

// File: rtl/fp_addsub_round_pack.sv
// Final round-and-pack stage of the FP add/sub unit: two pipeline registers,
// IEEE-754 rounding in four modes, exception overrides and sticky flags.
module fp_addsub_round_pack #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     zero_sum,
    input  logic [EXP_W:0]           norm_e,
    input  logic [MAN_W-1:0]         norm_m,
    input  logic                     g,
    input  logic                     r,
    input  logic                     s,
    input  logic                     sa,
    input  logic                     sb,
    input  logic                     ctrl,
    input  logic                     max_ab,
    input  logic                     neg_e,
    input  logic [4:0]               input_exc,
    input  logic [1:0]               rnd_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     p,
    output logic [4:0]               flags,
    input  logic                     flags_clr,
    output logic [4:0]               acc_flags
);
    localparam int unsigned ResW      = 1 + EXP_W + MAN_W;
    localparam int unsigned RndEW     = EXP_W + 2;
    localparam int unsigned ExpMaxInt = (1 << EXP_W) - 1;
    localparam logic [RndEW-1:0] ExpOvf = RndEW'(ExpMaxInt);

    typedef struct packed {
        logic             sign;
        logic [RndEW-1:0] rndE;
        logic [MAN_W-1:0] rndM;
        logic             inx;
        logic             negE;
        logic             excInv;
        logic             excInf;
        logic [1:0]       mode;
    } s1_t;

    logic v1, v2, ready2, load1, load2;
    s1_t  s1q, s1d;

    assign ready2   = ~v2 | out_ready;
    assign in_ready = ~v1 | ready2;
    assign load1    = in_valid & in_ready;
    assign load2    = v1 & ready2;
    assign out_valid = v2;

    // Stage 1: sign selection, rounding decision and mantissa/exponent increment
    logic             sbEff, zeroSign, inx, up, carry;
    logic [MAN_W:0]   sumM;
    always_comb begin
        s1d      = '0;
        sbEff    = sb ^ ctrl;
        zeroSign = (rnd_mode == 2'd3) ? (sa | sbEff) : (sa & sbEff);
        s1d.sign = zero_sum ? zeroSign : (max_ab ? sbEff : sa);
        inx      = g | r | s;
        case (rnd_mode)
            2'd0:    up = g & (r | s | norm_m[0]);
            2'd1:    up = 1'b0;
            2'd2:    up = ~s1d.sign & inx;
            default: up = s1d.sign & inx;
        endcase
        sumM  = {1'b0, norm_m} + (MAN_W+1)'(up);
        carry = sumM[MAN_W];
        s1d.rndM = carry ? '0 : sumM[MAN_W-1:0];
        s1d.rndE = {1'b0, norm_e} + RndEW'(carry);
        if (zero_sum) begin
            s1d.rndM = '0;
            s1d.rndE = '0;
        end
        s1d.inx    = inx;
        s1d.negE   = neg_e;
        s1d.excInv = |input_exc[4:2];
        s1d.excInf = input_exc[1] | input_exc[0];
        s1d.mode   = rnd_mode;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            s1q <= '0;
        end else begin
            if (in_ready) v1 <= in_valid;
            if (load1) s1q <= s1d;
        end
    end

    // Stage 2: overflow handling, exception overrides and flag generation
    logic            ovf, awayInf, noExc, ofl, ufl;
    logic [ResW-1:0] pD;
    logic [4:0]      flagsD;
    always_comb begin
        ovf     = s1q.rndE >= ExpOvf;
        awayInf = (s1q.mode == 2'd0) | ((s1q.mode == 2'd2) & ~s1q.sign)
                | ((s1q.mode == 2'd3) & s1q.sign);
        noExc   = ~s1q.excInv & ~s1q.excInf;
        if (s1q.excInv)
            pD = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        else if (s1q.excInf || (ovf && awayInf))
            pD = {s1q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (ovf)
            pD = {s1q.sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        else
            pD = {s1q.sign, s1q.rndE[EXP_W-1:0], s1q.rndM};
        ofl    = ovf & noExc;
        ufl    = s1q.negE & s1q.inx & noExc;
        flagsD = {ofl, ufl, 1'b0, s1q.excInv, (s1q.inx | ofl | ufl) & ~s1q.excInv};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            p     <= '0;
            flags <= '0;
        end else begin
            if (ready2) v2 <= v1;
            if (load2) begin
                p     <= pD;
                flags <= flagsD;
            end
        end
    end

    // Accumulated flags: a same-cycle clear never hides the flags being delivered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_flags <= '0;
        else if (out_valid && out_ready)
            acc_flags <= (flags_clr ? 5'b0 : acc_flags) | flags;
        else if (flags_clr)
            acc_flags <= '0;
    end
endmodule
